// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cond_pkg
// Description : Shared ARM condition-field encodings and NZCV flag bit indices
//               used by the conditional-execution logic.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // Instr[31:28] condition encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Purely combinational ARM condition evaluator. Maps the 4-bit
//               condition field and the {N,Z,C,V} flags onto a pass bit.
//               The reserved encoding 4'b1111 never passes.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;
    logic ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    // Decode the condition field against the current flags
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;   // COND_NV: reserved, never executes
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/condlogic.sv
`default_nettype none
// ============================================================================
// Module      : condlogic
// Description : Conditional-execution unit of the multicycle ARM core. Holds
//               the NZCV flags, registers the condition-pass bit one cycle
//               ahead of Execute and gates the decoder/FSM write requests.
//               Optional macro CONDLOGIC_PERF_EN adds fetch and squash
//               performance counters (FetchCnt, SquashCnt) of width CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module condlogic
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondExR
`ifdef CONDLOGIC_PERF_EN
    ,
    output logic [CNT_W-1:0] FetchCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("condlogic: CNT_W must be at least 1");
    end

    logic       cond_ex;
    logic [1:0] flag_write;

    // Condition is evaluated on the architectural flags only, not ALUFlags
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (cond_ex)
    );

    assign flag_write[1] = FlagW[1] & CondExR;
    assign flag_write[0] = FlagW[0] & CondExR;

    assign PCWrite  = (PCS & CondExR) | NextPC;
    assign RegWrite = RegW & CondExR;
    assign MemWrite = MemW & CondExR;

    // Condition-pass register and independently enabled flag halves; the pass
    // bit sampled on an edge sees the flags as they were before that edge
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags   <= 4'b0000;
            CondExR <= 1'b0;
        end else begin
            CondExR <= cond_ex;
            if (flag_write[1]) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (flag_write[0]) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

`ifdef CONDLOGIC_PERF_EN
    logic squash_sticky;
    logic squash_now;

    // Any request arriving while the condition failed marks the instruction
    assign squash_now = (PCS | RegW | MemW | (|FlagW)) & ~CondExR;

    // Count fetches; attribute a squash to the instruction ending at fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCnt      <= '0;
            SquashCnt     <= '0;
            squash_sticky <= 1'b0;
        end else begin
            if (NextPC) begin
                FetchCnt      <= FetchCnt + 1'b1;
                squash_sticky <= 1'b0;
                if (squash_sticky | squash_now) begin
                    SquashCnt <= SquashCnt + 1'b1;
                end
            end else if (squash_now) begin
                squash_sticky <= 1'b1;
            end
        end
    end
`endif

endmodule : condlogic
`default_nettype wire

// File: tb/tb_condlogic.sv
`default_nettype none
// ============================================================================
// Module      : tb_condlogic
// Description : Self-checking bench for condlogic. A table of directed
//               vectors (inputs plus hand-computed flags, pass bit and
//               strobes) is applied one per cycle; counters are exercised by
//               a hand-written sequence when CONDLOGIC_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condlogic;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic             CondExR;
`ifdef CONDLOGIC_PERF_EN
    logic [CNT_W-1:0] FetchCnt;
    logic [CNT_W-1:0] SquashCnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    condlogic #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondExR  (CondExR)
`ifdef CONDLOGIC_PERF_EN
        ,
        .FetchCnt (FetchCnt),
        .SquashCnt(SquashCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        // expected, observed before the next rising edge
        logic [3:0] e_flags;
        logic       e_condexr;
        logic       e_pcw;
        logic       e_regw;
        logic       e_memw;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        reset    = v.rst;
        Cond     = v.cond;
        ALUFlags = v.alu;
        FlagW    = v.flagw;
        PCS      = v.pcs;
        NextPC   = v.nextpc;
        RegW     = v.regw;
        MemW     = v.memw;
    endtask

    function automatic vec_t mk(logic rst, logic [3:0] cond, logic [3:0] alu, logic [1:0] fw,
                                logic pcs, logic npc, logic rw, logic mw,
                                logic [3:0] ef, logic ec, logic ep, logic er, logic em);
        vec_t v;
        v.rst = rst; v.cond = cond; v.alu = alu; v.flagw = fw;
        v.pcs = pcs; v.nextpc = npc; v.regw = rw; v.memw = mw;
        v.e_flags = ef; v.e_condexr = ec; v.e_pcw = ep; v.e_regw = er; v.e_memw = em;
        return v;
    endfunction

    task automatic idle(input logic [3:0] c, input logic npc, input logic mw);
        reset = 1'b0; Cond = c; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; NextPC = npc; RegW = 1'b0; MemW = mw;
    endtask

    initial begin
        //              rst cond     alu      fw     pcs npc rw mw | flags   cxr pcw rgw mw
        vecs[0]  = mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0); // AL, 1st cycle after reset
        vecs[1]  = mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0000, 1, 0, 1, 0); // AL, 2nd cycle
        vecs[2]  = mk(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0); // write Z
        vecs[3]  = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0); // EQ
        vecs[4]  = mk(0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0); // NE
        vecs[5]  = mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0); // NE failed
        vecs[6]  = mk(0, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0); // EQ + same-edge clear
        vecs[7]  = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0); // pre-update flags used
        vecs[8]  = mk(0, 4'b1110, 4'b1111, 2'b11, 1, 0, 0, 1, 4'b0000, 0, 0, 0, 0); // gated write/flags
        vecs[9]  = mk(0, 4'b1110, 4'b1011, 2'b10, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0); // N,Z only
        vecs[10] = mk(0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0); // LT
        vecs[11] = mk(0, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0); // C,V only
        vecs[12] = mk(0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0); // LT passed; GE
        vecs[13] = mk(0, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0); // GE passed; HI
        vecs[14] = mk(0, 4'b1111, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b1011, 1, 1, 0, 0); // HI passed; NV
        vecs[15] = mk(0, 4'b1110, 4'b0000, 2'b00, 1, 0, 1, 1, 4'b1011, 0, 0, 0, 0); // NV squashes all
        vecs[16] = mk(0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0); // clear flags
        vecs[17] = mk(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 1, 4'b0000, 1, 1, 0, 1); // AL strobes
        vecs[18] = mk(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 1, 4'b0000, 0, 0, 0, 0); // EQ fails
        vecs[19] = mk(0, 4'b0000, 4'b0000, 2'b00, 1, 1, 0, 1, 4'b0000, 0, 1, 0, 0); // NextPC forces
        vecs[20] = mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        vecs[21] = mk(0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0); // flags -> 1111
        vecs[22] = mk(1, 4'b1110, 4'b1010, 2'b11, 1, 0, 1, 0, 4'b1111, 1, 1, 1, 0); // reset mid-instr
        vecs[23] = mk(0, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 1, 4'b0000, 0, 1, 0, 0); // after reset
        vecs[24] = mk(0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0); // NV
        vecs[25] = mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0); // NV failed

        idle(4'b1110, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d Flags", i),    {28'd0, Flags},    {28'd0, vecs[i].e_flags});
            check($sformatf("v%0d CondExR", i),  {31'd0, CondExR},  {31'd0, vecs[i].e_condexr});
            check($sformatf("v%0d PCWrite", i),  {31'd0, PCWrite},  {31'd0, vecs[i].e_pcw});
            check($sformatf("v%0d RegWrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].e_regw});
            check($sformatf("v%0d MemWrite", i), {31'd0, MemWrite}, {31'd0, vecs[i].e_memw});
        end

`ifdef CONDLOGIC_PERF_EN
        // Three fetches; the second instruction's MemW arrives under NV
        @(negedge clk); idle(4'b1110, 1'b0, 1'b0); reset = 1'b1;
        @(negedge clk); idle(4'b1110, 1'b0, 1'b0);
        #1;
        check("perf FetchCnt reset",  FetchCnt,  32'd0);
        check("perf SquashCnt reset", SquashCnt, 32'd0);
        idle(4'b1110, 1'b1, 1'b0);               // fetch 1
        @(negedge clk); idle(4'b1111, 1'b0, 1'b0);
        @(negedge clk); idle(4'b1111, 1'b1, 1'b0); // fetch 2
        @(negedge clk); idle(4'b1111, 1'b0, 1'b1); // squashed MemW
        #1;
        check("perf FetchCnt mid",  FetchCnt,  32'd2);
        check("perf SquashCnt mid", SquashCnt, 32'd0);
        @(negedge clk); idle(4'b1110, 1'b1, 1'b0); // fetch 3
        @(negedge clk); idle(4'b1110, 1'b0, 1'b0);
        #1;
        check("perf FetchCnt",  FetchCnt,  32'd3);
        check("perf SquashCnt", SquashCnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_condlogic
`default_nettype wire
